// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the command scheduler: opcode table, engine slot
// indices, FSM state encoding and default parameter values.
package cmd_sched_pkg;

  localparam int          N_ENG_DEF     = 8;
  localparam logic [7:0]  NAK_BYTE_DEF  = 8'h3F;
  localparam int          TIMEOUT_W_DEF = 24;

  // Opcodes understood by the scheduler
  localparam logic [7:0] OP_SAMPLER   = 8'h21;
  localparam logic [7:0] OP_SAMPLE_RD = 8'h22;
  localparam logic [7:0] OP_MEM_CLR   = 8'h23;
  localparam logic [7:0] OP_OFFSET    = 8'h24;
  localparam logic [7:0] OP_ADC_SEL   = 8'h25;
  localparam logic [7:0] OP_TRIG_CFG  = 8'h31;
  localparam logic [7:0] OP_REPLAYER  = 8'h71;
  localparam logic [7:0] OP_REPLY_CNT = 8'h72;

  // Engine slot index for each opcode
  localparam int ENG_SAMPLER   = 0;
  localparam int ENG_SAMPLE_RD = 1;
  localparam int ENG_MEM_CLR   = 2;
  localparam int ENG_OFFSET    = 3;
  localparam int ENG_ADC_SEL   = 4;
  localparam int ENG_TRIG_CFG  = 5;
  localparam int ENG_REPLAYER  = 6;
  localparam int ENG_REPLY_CNT = 7;

  // Opcode table: entry i is the opcode that grants engine slot i
  localparam logic [7:0] OP_TABLE [N_ENG_DEF] = '{
    OP_SAMPLER, OP_SAMPLE_RD, OP_MEM_CLR, OP_OFFSET,
    OP_ADC_SEL, OP_TRIG_CFG, OP_REPLAYER, OP_REPLY_CNT
  };

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_NAK_SEND = 3'd2,
    ST_NAK_WAIT = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

endpackage

// File: rtl/cmd_scheduler_if.sv
// Bus bundle between the command scheduler and its UART / engine neighbours.
//
// Handshake semantics:
//   rx_ready is a one-cycle byte-valid strobe; rx_data is only meaningful
//   while it is high. tx_start asks uart_tx to send tx_data; uart_tx
//   acknowledges by raising tx_active and holds it for the whole transmit.
//   eng_activate is a level grant held until the engine's eng_done strobe.
interface cmd_scheduler_if
  import cmd_sched_pkg::*;
#(
  parameter int N_ENG = N_ENG_DEF
);
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               tx_active;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic [N_ENG-1:0]   eng_activate;
  logic [N_ENG-1:0]   eng_done;
  logic [8*N_ENG-1:0] eng_tx_data;
  logic [N_ENG-1:0]   eng_tx_start;
  logic               busy;
  logic [7:0]         cur_cmd;
  logic               timeout;
  state_t             state_dbg;

  // Scheduler side
  modport master (
    input  rx_data, rx_ready, tx_active, eng_done, eng_tx_data, eng_tx_start,
    output tx_data, tx_start, eng_activate, busy, cur_cmd, timeout, state_dbg
  );

  // Environment side (UART front end and engines)
  modport slave (
    output rx_data, rx_ready, tx_active, eng_done, eng_tx_data, eng_tx_start,
    input  tx_data, tx_start, eng_activate, busy, cur_cmd, timeout, state_dbg
  );
endinterface

// File: rtl/cmd_decode.sv
// Combinational opcode decoder: opcode byte -> {valid, one-hot engine slot}.
module cmd_decode
  import cmd_sched_pkg::*;
#(
  parameter int N_ENG = N_ENG_DEF
) (
  input  logic [7:0]       opcode,
  output logic             valid,
  output logic [N_ENG-1:0] onehot
);

  // Compare against every table entry; table entries are distinct so at most one bit sets
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (opcode == OP_TABLE[i]) onehot[i] = 1'b1;
    end
    valid = |onehot;
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Central command sequencer: decodes an opcode byte, grants one engine,
// muxes that engine onto the shared uart_tx port, NAKs unknown opcodes.
// Optional RUN watchdog enabled by defining CMD_WATCHDOG_EN.
module cmd_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int         N_ENG     = N_ENG_DEF,
  parameter logic [7:0] NAK_BYTE  = NAK_BYTE_DEF,
  parameter int         TIMEOUT_W = TIMEOUT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  cmd_scheduler_if.master bus
);

  // The opcode table is fixed in the package, so the slot count must match it
  if (N_ENG != N_ENG_DEF) begin : g_neng_check
    $error("N_ENG must equal the package opcode table size");
  end
  if (TIMEOUT_W < 2) begin : g_tw_check
    $error("TIMEOUT_W must be at least 2");
  end

  state_t           state_q, state_d;
  logic [N_ENG-1:0] grant_q, grant_d;
  logic [7:0]       cur_cmd_q, cur_cmd_d;
  logic [7:0]       tx_data_q;
  logic [7:0]       tx_data_o;
  logic             tx_start_o;
  logic             dec_valid;
  logic [N_ENG-1:0] dec_onehot;
  logic [7:0]       mux_data;
  logic             mux_start;
  logic             done_hit;

`ifdef CMD_WATCHDOG_EN
  logic                 timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
`endif

  cmd_decode #(.N_ENG(N_ENG)) u_decode (
    .opcode (bus.rx_data),
    .valid  (dec_valid),
    .onehot (dec_onehot)
  );

  // AND-OR mux of the granted engine's transmit request (grant is one-hot)
  always_comb begin
    mux_data  = '0;
    mux_start = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      if (grant_q[i]) begin
        mux_data  = mux_data | bus.eng_tx_data[8*i +: 8];
        mux_start = mux_start | bus.eng_tx_start[i];
      end
    end
  end

  // Only the granted engine's done counts
  assign done_hit = |(bus.eng_done & grant_q);

`ifdef CMD_WATCHDOG_EN
  assign cnt_inc = cnt_q + 1'b1;
`endif

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cur_cmd_d  = cur_cmd_q;
    tx_data_o  = tx_data_q;
    tx_start_o = 1'b0;
`ifdef CMD_WATCHDOG_EN
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_ready) begin
          cur_cmd_d = bus.rx_data;
          if (dec_valid) begin
            grant_d = dec_onehot;
            state_d = ST_RUN;
`ifdef CMD_WATCHDOG_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = ST_NAK_SEND;
          end
        end
      end
      ST_RUN: begin
        tx_data_o  = mux_data;
        tx_start_o = mux_start;
        // Incoming rx bytes belong to the engine here and are not decoded
        if (done_hit) begin
          grant_d = '0;
          state_d = ST_DRAIN;
        end
`ifdef CMD_WATCHDOG_EN
        else if (&cnt_inc) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      ST_NAK_SEND: begin
        tx_data_o  = NAK_BYTE;
        tx_start_o = ~bus.tx_active;
        if (bus.tx_active) state_d = ST_NAK_WAIT;
      end
      ST_NAK_WAIT: begin
        if (!bus.tx_active) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait out trailing bytes and in-flight transmits before re-arming
        if (!bus.rx_ready && !bus.tx_active) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      cur_cmd_q <= 8'h00;
      tx_data_q <= 8'h00;
`ifdef CMD_WATCHDOG_EN
      timeout_q <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cur_cmd_q <= cur_cmd_d;
      tx_data_q <= tx_data_o;
`ifdef CMD_WATCHDOG_EN
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.tx_data      = tx_data_o;
  assign bus.tx_start     = tx_start_o;
  assign bus.eng_activate = grant_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.cur_cmd      = cur_cmd_q;
  assign bus.state_dbg    = state_q;
`ifdef CMD_WATCHDOG_EN
  assign bus.timeout      = timeout_q;
`else
  assign bus.timeout      = 1'b0;
`endif

  // The grant may never name more than one engine
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: decode vector table, directed
// multi-cycle sequences, and randomized commands checked against a
// transaction-level reference of the opcode table and tx mux rules.
module tb_cmd_scheduler;
  import cmd_sched_pkg::*;

  localparam int N_ENG = 8;
`ifdef CMD_WATCHDOG_EN
  localparam int TW = 4;
`else
  localparam int TW = 24;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_scheduler_if #(.N_ENG(N_ENG)) bus ();

  cmd_scheduler #(
    .N_ENG     (N_ENG),
    .NAK_BYTE  (8'h3F),
    .TIMEOUT_W (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] dec_op;
  logic       dec_valid;
  logic [7:0] dec_oh;

  cmd_decode #(.N_ENG(N_ENG)) u_dec (
    .opcode (dec_op),
    .valid  (dec_valid),
    .onehot (dec_oh)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] op;
    logic       valid;
    logic [7:0] oh;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference grant straight from the opcode list
  function automatic logic [7:0] ref_grant(input logic [7:0] op);
    case (op)
      8'h21: return 8'b0000_0001;
      8'h22: return 8'b0000_0010;
      8'h23: return 8'b0000_0100;
      8'h24: return 8'b0000_1000;
      8'h25: return 8'b0001_0000;
      8'h31: return 8'b0010_0000;
      8'h71: return 8'b0100_0000;
      8'h72: return 8'b1000_0000;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int slot_of(input logic [7:0] g);
    for (int i = 0; i < 8; i++) if (g[i]) return i;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.rx_data      = 8'h00;
    bus.rx_ready     = 1'b0;
    bus.tx_active    = 1'b0;
    bus.eng_done     = '0;
    bus.eng_tx_data  = '0;
    bus.eng_tx_start = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_activate"}, bus.eng_activate, 0);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_cur_cmd"}, bus.cur_cmd, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    bus.rx_data  = op;
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    chk("cur_cmd", bus.cur_cmd, op);
    chk("busy_after_cmd", bus.busy, 1);
  endtask

  // Engine runs for 'cycles' cycles with random traffic, then signals done
  task automatic run_engine(input logic [7:0] grant, input int cycles, input bit rx_with_done);
    int idx;
    logic [7:0] last_data;
    idx = slot_of(grant);
    for (int c = 0; c < cycles; c++) begin
      bus.eng_tx_data  = {$urandom(), $urandom()};
      bus.eng_tx_start = 8'($urandom());
      bus.eng_done     = 8'($urandom()) & ~grant;
      bus.rx_ready     = 1'($urandom_range(0, 1));
      bus.rx_data      = 8'($urandom());
      bus.tx_active    = 1'($urandom_range(0, 1));
      #1;
      chk("run_tx_data", bus.tx_data, bus.eng_tx_data[8*idx +: 8]);
      chk("run_tx_start", bus.tx_start, bus.eng_tx_start[idx]);
      step();
      chk("run_activate", bus.eng_activate, grant);
    end
    bus.eng_tx_data  = {$urandom(), $urandom()};
    bus.eng_tx_start = 8'($urandom());
    bus.eng_done     = grant | (8'($urandom()) & ~grant);
    bus.rx_ready     = rx_with_done;
    bus.rx_data      = 8'h21;
    bus.tx_active    = 1'b0;
    #1;
    last_data = bus.eng_tx_data[8*idx +: 8];
    chk("done_tx_data", bus.tx_data, last_data);
    step();
    bus.eng_done     = '0;
    bus.rx_ready     = 1'b0;
    bus.eng_tx_start = '0;
    chk("done_activate", bus.eng_activate, 0);
    chk("drain_busy", bus.busy, 1);
    #1;
    chk("drain_tx_start", bus.tx_start, 0);
    chk("drain_tx_hold", bus.tx_data, last_data);
  endtask

  // Hold tx_active for 'hold' cycles in DRAIN, then release and expect IDLE
  task automatic drain(input int hold);
    bus.tx_active = 1'b1;
    for (int c = 0; c < hold; c++) begin
      step();
      chk("drain_hold_busy", bus.busy, 1);
    end
    bus.tx_active = 1'b0;
    step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_activate", bus.eng_activate, 0);
  endtask

  // NAK transmit: k cycles waiting for uart_tx, m cycles of transmit
  task automatic nak_seq(input int k, input int m);
    chk("nak_activate", bus.eng_activate, 0);
    bus.tx_active = 1'b0;
    for (int c = 0; c < k; c++) begin
      #1;
      chk("nak_tx_data", bus.tx_data, 8'h3F);
      chk("nak_tx_start", bus.tx_start, 1);
      step();
    end
    bus.tx_active = 1'b1;
    #1;
    chk("nak_start_drop", bus.tx_start, 0);
    step();
    for (int c = 0; c < m; c++) begin
      chk("nak_wait_start", bus.tx_start, 0);
      chk("nak_wait_busy", bus.busy, 1);
      chk("nak_wait_activate", bus.eng_activate, 0);
      step();
    end
    bus.tx_active = 1'b0;
    step();
    chk("nak_drain_busy", bus.busy, 1);
    step();
    chk("nak_idle_busy", bus.busy, 0);
    chk("nak_hold_data", bus.tx_data, 8'h3F);
    chk("nak_idle_start", bus.tx_start, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] op;
    logic [7:0] g;
    logic [7:0] known [8];

    vecs[0]  = '{8'h21, 1'b1, 8'h01};
    vecs[1]  = '{8'h22, 1'b1, 8'h02};
    vecs[2]  = '{8'h23, 1'b1, 8'h04};
    vecs[3]  = '{8'h24, 1'b1, 8'h08};
    vecs[4]  = '{8'h25, 1'b1, 8'h10};
    vecs[5]  = '{8'h31, 1'b1, 8'h20};
    vecs[6]  = '{8'h71, 1'b1, 8'h40};
    vecs[7]  = '{8'h72, 1'b1, 8'h80};
    vecs[8]  = '{8'h55, 1'b0, 8'h00};
    vecs[9]  = '{8'h00, 1'b0, 8'h00};
    vecs[10] = '{8'h20, 1'b0, 8'h00};
    vecs[11] = '{8'h73, 1'b0, 8'h00};
    known = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h31, 8'h71, 8'h72};

    idle_inputs();
    dec_op = 8'h00;
    rst = 1'b1;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Vector table: decoder alone, then through the scheduler
    for (int v = 0; v < 12; v++) begin
      dec_op = vecs[v].op;
      #1;
      chk("dec_valid", dec_valid, vecs[v].valid);
      chk("dec_onehot", dec_oh, vecs[v].oh);
      send_cmd(vecs[v].op);
      chk("vec_activate", bus.eng_activate, vecs[v].oh);
      if (vecs[v].valid) begin
        run_engine(vecs[v].oh, 2, 1'b0);
        drain(1);
      end else begin
        nak_seq(1, 1);
      end
    end

    // Accept and complete with a long drain
    send_cmd(8'h22);
    chk("accept_activate", bus.eng_activate, 8'b0000_0010);
    run_engine(8'b0000_0010, 1, 1'b0);
    drain(10);

    // TX mux for engine 6 against all-ones neighbours
    send_cmd(8'h71);
    bus.eng_tx_data  = {8'hFF, 8'hA5, {6{8'hFF}}};
    bus.eng_tx_start = 8'hFF;
    #1;
    chk("mux6_data", bus.tx_data, 8'hA5);
    chk("mux6_start", bus.tx_start, 1);
    bus.eng_tx_start = 8'b1011_1111;
    #1;
    chk("mux6_start_low", bus.tx_start, 0);
    run_engine(8'h40, 0, 1'b0);
    drain(0);

    // Unknown opcode
    send_cmd(8'h55);
    nak_seq(3, 2);

    // Bytes during RUN are ignored; done beats a coincident rx_ready
    send_cmd(8'h31);
    bus.rx_data  = 8'h21;
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    chk("rxrun_activate", bus.eng_activate, 8'h20);
    chk("rxrun_cur_cmd", bus.cur_cmd, 8'h31);
    run_engine(8'h20, 2, 1'b1);
    chk("rxdone_cur_cmd", bus.cur_cmd, 8'h31);
    drain(0);

    // Reset in the middle of RUN
    send_cmd(8'h21);
    chk("pre_rst_activate", bus.eng_activate, 8'h01);
    rst = 1'b1;
    step();
    check_reset_values("midrun_rst");
    rst = 1'b0;
    send_cmd(8'h22);
    chk("post_rst_activate", bus.eng_activate, 8'h02);
    run_engine(8'h02, 1, 1'b0);
    drain(0);

`ifdef CMD_WATCHDOG_EN
    begin
      int n;
      send_cmd(8'h23);
      n = 0;
      while (bus.eng_activate != 0 && n < 40) begin
        step();
        n++;
      end
      chk("wd_run_cycles", n, 15);
      chk("wd_timeout", bus.timeout, 1);
      chk("wd_busy", bus.busy, 1);
      drain(0);
      send_cmd(8'h24);
      chk("wd_sticky", bus.timeout, 1);
      run_engine(8'h08, 1, 1'b0);
      drain(0);
      chk("wd_sticky_idle", bus.timeout, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("wd_rst_clear", bus.timeout, 0);
    end
`endif

    // Randomized commands against the reference table
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) != 0) op = known[$urandom_range(0, 7)];
      else op = 8'($urandom());
      exp_q.push_back(ref_grant(op));
      send_cmd(op);
      g = exp_q.pop_front();
      chk("rand_activate", bus.eng_activate, g);
      if (g != 0) begin
        run_engine(g, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        drain($urandom_range(0, 3));
      end else begin
        nak_seq($urandom_range(1, 3), $urandom_range(0, 3));
      end
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
